// File: rtl/ram_burst_master_if.sv
// ram_burst_master_if: command, write-stream, read-stream and RAM pin bundle
//   cmd_*  : burst command (valid/ready), write flag, start address, beats-1
//   wr_*   : write data stream into the master
//   rd_*   : read data stream out of the master, plus done pulse
//   ram_*  : RAM pins (we/addr/D out of the master, combinational Q in)
//   master : the burst controller side; slave : client + RAM side
interface ram_burst_master_if #(parameter int Width = 8, parameter int AddressSize = 4);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AddressSize-1:0] cmd_addr, cmd_len;
  logic wr_valid, wr_ready;
  logic [Width-1:0] wr_data;
  logic rd_valid, rd_ready;
  logic [Width-1:0] rd_data;
  logic done, ram_we;
  logic [AddressSize-1:0] ram_addr;
  logic [Width-1:0] ram_d, ram_q;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_q,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, ram_we, ram_addr, ram_d
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_q,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, ram_we, ram_addr, ram_d
  );
endinterface

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst read/write controller driving a combinational-read RAM
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ram_burst_master_if.master (command port, write/read streams, RAM pins)
module ram_burst_master #(
  parameter int Width = 8,
  parameter int AddressSize = 4
) (
  input logic clk,
  input logic rst,
  ram_burst_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state_q, state_d;
  logic [AddressSize-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic accept, beat, last;
  // every strobe decodes straight from the state flop, so async reset clears them at once
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.wr_ready  = state_q == WRITE;
  assign bus.rd_valid  = state_q == READ;
  assign bus.done      = state_q == DONE;
  assign bus.ram_we    = state_q == WRITE && bus.wr_valid;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_d     = Width'(bus.wr_data);
  assign bus.rd_data   = Width'(bus.ram_q);
  always_comb begin
    accept  = state_q == IDLE && bus.cmd_valid;
    beat    = (state_q == WRITE && bus.wr_valid) || (state_q == READ && bus.rd_ready);
    last    = cnt_q == '0;
    state_d = accept ? (bus.cmd_write ? WRITE : READ)
            : beat && last ? DONE
            : state_q == DONE ? IDLE
            : state_q;
    // address wraps naturally at the width of addr_q
    addr_d  = accept ? bus.cmd_addr : beat ? addr_q + AddressSize'(1) : addr_q;
    cnt_d   = accept ? bus.cmd_len : beat && !last ? cnt_q - AddressSize'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
